// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state codes and debug-select constants
// for the data memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [2:0] DBG_RDATA = 3'd0;
  localparam logic [2:0] DBG_ADDR  = 3'd1;
  localparam logic [2:0] DBG_NXFER = 3'd2;
  localparam logic [2:0] DBG_NERR  = 3'd3;
  localparam logic [2:0] DBG_STATE = 3'd4;

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: DEPTH x DATA_W storage, synchronous write, one async
// read port; reads beyond DEPTH return zero. Contents not reset.
module dmem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_rd_ok;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign w_rd_ok = ({1'b0, i_raddr} < LIM);
  assign o_rdata = w_rd_ok ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: CPU data memory controller, IDLE/WAIT/RESP handshake.
// Debug readout on dbg_y is compiled only with DMEM_DBG_PORT_EN.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_y
);

  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [2:0]      WC  = 3'(WAIT_CYCLES);

  state_e            r_state;
  state_e            w_next;
  logic [2:0]        r_cnt;
  logic [2:0]        w_cnt_nxt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_oor;
  logic [DATA_W-1:0] r_rdata;

  logic              w_accept;
  logic              w_ack;
  logic              w_wr;
  logic              w_to_resp;
  logic [ADDR_W-1:0] w_raddr;
  logic [DATA_W-1:0] w_ram_rd;

  assign w_accept  = (r_state == ST_IDLE) && req && enable;
  assign w_ack     = (r_state == ST_RESP) && enable;
  assign w_wr      = w_ack && r_we && !r_oor;
  assign w_to_resp = enable && (w_next == ST_RESP)
                  && (r_state != ST_RESP);
  // In IDLE the live address is read so zero-wait reads still work
  assign w_raddr   = (r_state == ST_IDLE) ? addr : r_addr;

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (req) begin
          if (WC == 3'd0) begin
            w_next = ST_RESP;
          end else begin
            w_next    = ST_WAIT;
            w_cnt_nxt = WC;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt <= 3'd1) begin
          w_next    = ST_RESP;
          w_cnt_nxt = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_oor   <= 1'b0;
      r_rdata <= '0;
    end else if (enable) begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we    <= we;
        r_addr  <= addr;
        r_wdata <= wdata;
        r_oor   <= ({1'b0, addr} >= LIM);
      end
      if (w_to_resp) begin
        r_rdata <= w_ram_rd;
      end
    end
  end

  dmem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_addr),
    .i_wdata (r_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_rd)
  );

  assign rdata = r_rdata;
  assign ack   = w_ack;
  assign err   = w_ack && r_oor;
  assign busy  = (r_state != ST_IDLE);

`ifdef DMEM_DBG_PORT_EN
  logic [DATA_W-1:0] r_nxfer;
  logic [DATA_W-1:0] r_nerr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_nxfer <= '0;
      r_nerr  <= '0;
    end else if (w_ack) begin
      r_nxfer <= r_nxfer + DATA_W'(1);
      if (r_oor) begin
        r_nerr <= r_nerr + DATA_W'(1);
      end
    end
  end

  always_comb begin
    dbg_y = '0;
    unique case (1'b1)
      (dbg_sel == DBG_RDATA): dbg_y = r_rdata;
      (dbg_sel == DBG_ADDR):  dbg_y = DATA_W'(r_addr);
      (dbg_sel == DBG_NXFER): dbg_y = r_nxfer;
      (dbg_sel == DBG_NERR):  dbg_y = r_nerr;
      (dbg_sel == DBG_STATE): dbg_y = DATA_W'(r_state);
      default:                dbg_y = '0;
    endcase
  end
`else
  // dbg_sel still feeds the (always zero) output so the port is used
  assign dbg_y = {DATA_W{1'b0}} & {DATA_W{^dbg_sel}};
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: three controller configs driven with random and
// directed accesses, checked against an array-based memory model.
module tb_data_mem_ctrl;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst   [NI];
  logic        en    [NI];
  logic        req   [NI];
  logic        we    [NI];
  logic [7:0]  addr  [NI];
  logic [15:0] wdata [NI];
  logic [15:0] rdata [NI];
  logic        ack   [NI];
  logic        err   [NI];
  logic        busy  [NI];
  logic [15:0] dbg_y [NI];
  logic [2:0]  dbg_sel;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    data_mem_ctrl #(
      .ADDR_W      (8),
      .DATA_W      (16),
      .DEPTH       ((g == 2) ? 200 : 256),
      .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk     (clk),
      .reset   (rst[g]),
      .enable  (en[g]),
      .req     (req[g]),
      .we      (we[g]),
      .addr    (addr[g]),
      .wdata   (wdata[g]),
      .rdata   (rdata[g]),
      .ack     (ack[g]),
      .err     (err[g]),
      .busy    (busy[g]),
      .dbg_sel (dbg_sel),
      .dbg_y   (dbg_y[g])
    );
  end

  function automatic int wc(int n);
    return (n == 0) ? 1 : ((n == 1) ? 0 : 3);
  endfunction

  function automatic int dep(int n);
    return (n == 2) ? 200 : 256;
  endfunction

  // reference model
  logic [15:0] mm  [NI][256];
  bit          mv  [NI][256];
  int          nx  [NI];
  int          ne  [NI];
  logic [7:0]  la  [NI];
  logic [15:0] lrd [NI];
  bit          lrk [NI];

  int checks   = 0;
  int failures = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic txn(int n, bit w, logic [7:0] a,
                     logic [15:0] d, int stall);
    int  lat;
    bit  oor;
    int  exp_lat;
    oor     = (int'(a) >= dep(n));
    exp_lat = wc(n) + 1 + stall;
    lat     = 0;
    @(negedge clk);
    check($sformatf("i%0d_idle_busy", n), busy[n], 0);
    req[n] = 1'b1; we[n] = w; addr[n] = a; wdata[n] = d;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (ack[n]) begin
        lat = k;
        break;
      end
      check($sformatf("i%0d_busy_inflight", n), busy[n], 1);
      if (k == 1) begin
        we[n] = 1'($urandom); addr[n] = 8'($urandom);
        wdata[n] = 16'($urandom);
      end
      if (stall > 0 && k == 1) en[n] = 1'b0;
      if (stall > 0 && k == 1 + stall) en[n] = 1'b1;
    end
    check($sformatf("i%0d_latency a=%0h", n, a), lat, exp_lat);
    if (lat != 0) begin
      check($sformatf("i%0d_err a=%0h", n, a), err[n], oor);
      if (oor)
        check($sformatf("i%0d_oor_rdata", n), rdata[n], 0);
      else if (!w && mv[n][a])
        check($sformatf("i%0d_rdata a=%0h", n, a), rdata[n], mm[n][a]);
    end
    if (w && !oor) begin
      mm[n][a] = d;
      mv[n][a] = 1'b1;
    end
    nx[n]++;
    if (oor) ne[n]++;
    la[n]  = a;
    lrk[n] = !w && (oor || mv[n][a]);
    lrd[n] = oor ? 16'h0 : mm[n][a];
    req[n] = 1'b0;
  endtask

  task automatic rst_mid(int n, logic [7:0] a, logic [15:0] d);
    @(negedge clk);
    req[n] = 1'b1; we[n] = 1'b1; addr[n] = a; wdata[n] = d;
    @(negedge clk);
    check("rst_mid_ack_pre", ack[n], 0);
    check("rst_mid_busy_pre", busy[n], 1);
    rst[n] = 1'b1; req[n] = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busy[n], 0);
    check("rst_mid_ack", ack[n], 0);
    check("rst_mid_rdata", rdata[n], 0);
    rst[n] = 1'b0;
    nx[n] = 0; ne[n] = 0; la[n] = 8'h0; lrd[n] = 16'h0; lrk[n] = 1'b1;
  endtask

  task automatic check_dbg(int n);
    txn(n, 1'b1, 8'h01, 16'($urandom), 0);
    txn(n, 1'b0, 8'h01, 16'h0, 0);
    @(negedge clk);
    for (int s = 0; s < 8; s++) begin
      dbg_sel = 3'(s);
      #1;
`ifdef DMEM_DBG_PORT_EN
      case (s)
        0: if (lrk[n]) check($sformatf("i%0d_dbg_rdata", n), dbg_y[n], lrd[n]);
        1: check($sformatf("i%0d_dbg_addr", n), dbg_y[n], {8'h0, la[n]});
        2: check($sformatf("i%0d_dbg_nxfer", n), dbg_y[n], 16'(nx[n]));
        3: check($sformatf("i%0d_dbg_nerr", n), dbg_y[n], 16'(ne[n]));
        4: check($sformatf("i%0d_dbg_state", n), dbg_y[n], 0);
        default: check($sformatf("i%0d_dbg_zero%0d", n, s), dbg_y[n], 0);
      endcase
`else
      check($sformatf("i%0d_dbg_off%0d", n, s), dbg_y[n], 0);
`endif
    end
    dbg_sel = 3'd0;
  endtask

  logic [7:0]  ra;
  logic [15:0] prior;

  initial begin
    dbg_sel = 3'd0;
    for (int n = 0; n < NI; n++) begin
      rst[n] = 1'b1; en[n] = 1'b1; req[n] = 1'b0; we[n] = 1'b0;
      addr[n] = 8'h0; wdata[n] = 16'h0;
      nx[n] = 0; ne[n] = 0; la[n] = 8'h0; lrd[n] = 16'h0; lrk[n] = 1'b1;
      for (int a = 0; a < 256; a++) mv[n][a] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int n = 0; n < NI; n++) begin
      check($sformatf("i%0d_rst_ack", n), ack[n], 0);
      check($sformatf("i%0d_rst_err", n), err[n], 0);
      check($sformatf("i%0d_rst_busy", n), busy[n], 0);
      check($sformatf("i%0d_rst_rdata", n), rdata[n], 0);
      check($sformatf("i%0d_rst_dbg", n), dbg_y[n], 0);
      rst[n] = 1'b0;
    end

    // config 0: one wait state
    txn(0, 1'b1, 8'h05, 16'h1234, 0);
    txn(0, 1'b0, 8'h05, 16'h0, 0);
    repeat (40) begin
      ra = $urandom_range(0, 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      txn(0, 1'($urandom), ra, 16'($urandom), 0);
    end
    prior = 16'($urandom);
    txn(0, 1'b1, 8'h10, prior, 0);
    rst_mid(0, 8'h10, 16'h00FF);
    txn(0, 1'b0, 8'h10, 16'h0, 0);
    check("rst_mid_prior", rdata[0], prior);
    check_dbg(0);

    // config 1: zero wait, back-to-back reads with req held
    for (int a = 0; a < 8; a++) txn(1, 1'b1, 8'(a), 16'($urandom), 0);
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0;
    ra = 8'($urandom_range(0, 7)); addr[1] = ra;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("held_ack k=%0d", k), ack[1], (k % 2 == 1));
      check($sformatf("held_busy k=%0d", k), busy[1], (k % 2 == 1));
      if (k % 2 == 1) begin
        check($sformatf("held_rdata k=%0d", k), rdata[1], mm[1][ra]);
        nx[1]++; la[1] = ra; lrd[1] = mm[1][ra]; lrk[1] = 1'b1;
        ra = 8'($urandom_range(0, 7)); addr[1] = ra;
      end
      if (k == 10) req[1] = 1'b0;
    end
    repeat (20) begin
      ra = 8'($urandom_range(0, 15));
      txn(1, 1'($urandom), ra, 16'($urandom), 0);
    end
    check_dbg(1);

    // config 2: three wait states, DEPTH 200
    txn(2, 1'b1, 8'h00, 16'hA5A5, 0);
    txn(2, 1'b1, 8'hC7, 16'h5A5A, 0);
    txn(2, 1'b1, 8'hC8, 16'hBEEF, 0);
    txn(2, 1'b0, 8'hC8, 16'h0, 0);
    txn(2, 1'b0, 8'h00, 16'h0, 0);
    txn(2, 1'b0, 8'hC7, 16'h0, 0);
    txn(2, 1'b0, 8'h00, 16'h0, 3);
    txn(2, 1'b1, 8'h20, 16'h7777, 3);
    txn(2, 1'b0, 8'h20, 16'h0, 0);
    repeat (30) begin
      ra = 8'($urandom_range(180, 255));
      txn(2, 1'($urandom), ra, 16'($urandom), $urandom_range(0, 1) * 2);
    end
    check_dbg(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, data address width.
REQ-002 SHALL have parameter DATA_W, default 16, data word width.
REQ-003 SHALL have parameter DEPTH, default 256, implemented words (1..2**ADDR_W).
REQ-004 SHALL have parameter WAIT_CYCLES, default 1, added access latency (0..7).
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port enable  input  1  global clock enable; low freezes all state.
REQ-008 SHALL have port req  input  1  CPU access request, held until ack.
REQ-009 SHALL have port we  input  1  1 = write, 0 = read; sampled at accept.
REQ-010 SHALL have port addr  input  ADDR_W  word address; sampled at accept.
REQ-011 SHALL have port wdata  input  DATA_W  write data; sampled at accept.
REQ-012 SHALL have port rdata  output  DATA_W  read data; valid in ack cycle, held until next ack.
REQ-013 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-014 SHALL have port err  output  1  valid with ack; 1 = address >= DEPTH.
REQ-015 SHALL have port busy  output  1  high while a transaction is in flight (CPU stall).
REQ-016 SHALL have port dbg_sel  input  3  debug word select.
REQ-017 SHALL have port dbg_y  output  DATA_W  selected debug word.

Function
REQ-018 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; WAIT skipped when WAIT_CYCLES = 0.
REQ-019 SHALL accept in IDLE when req && enable; capture we/addr/wdata; busy = 1 from next cycle.
REQ-020 SHALL remain in WAIT for exactly WAIT_CYCLES enabled cycles, counted by a 3-bit down-counter.
REQ-021 SHALL assert ack in RESP only (ack = RESP && enable); accept at cycle t gives ack at t+WAIT_CYCLES+1.
REQ-022 SHALL commit a write at the end of the ack cycle; a read returns the word as stored before that edge.
REQ-023 SHALL ignore req outside IDLE; next accept earliest in the cycle after ack (busy low there).
REQ-024 SHALL, for addr >= DEPTH, suppress the write, return rdata = 0, and assert err with ack.
REQ-025 SHALL, with enable low, hold FSM, counter, memory, rdata and debug counters unchanged; ack = 0.
REQ-026 SHALL leave memory contents uninitialised after power-up; contents are not a reset target.

Reset
REQ-027 SHALL on reset force IDLE, counter 0, rdata 0, ack 0, err 0, busy 0, debug registers 0.
REQ-028 SHALL on reset mid-transaction abort it: no ack, no write commit, memory otherwise unchanged.
REQ-029 SHALL give reset priority over enable and req in the same cycle.

Configuration
REQ-030 SHALL compile the debug block only when macro DMEM_DBG_PORT_EN is defined.
REQ-031 SHALL with DMEM_DBG_PORT_EN map dbg_sel: 0 last rdata, 1 last accepted addr (zero-extended), 2 completed-transaction count, 3 err count, 4 FSM state code, 5-7 zero.
REQ-032 SHALL wrap both debug counters modulo 2**DATA_W, incrementing on ack.
REQ-033 SHALL without DMEM_DBG_PORT_EN tie dbg_y to 0, keep the port list identical, and instantiate no debug registers.

Structure
REQ-034 SHALL place the FSM state enum, state codes and dbg_sel constants in shared package dmem_pkg.
REQ-035 SHALL isolate storage in sub-module dmem_ram (DEPTH x DATA_W, synchronous write, one read port).

Verification
REQ-036 SHALL test: WAIT_CYCLES=1, write 0x1234 @0x05 at t=10, then read @0x05 -> ack at t=12, later ack with rdata=0x1234, err=0.
REQ-037 SHALL test: WAIT_CYCLES=0, back-to-back reads with req held -> ack every 2nd cycle, busy low only in IDLE cycles.
REQ-038 SHALL test: DEPTH=200, write 0xBEEF @0xC8 -> ack with err=1; read @0xC8 returns 0, earlier contents @0x00-0xC7 unchanged.
REQ-039 SHALL test: enable low for 3 cycles during WAIT (WAIT_CYCLES=3) -> ack delayed by exactly 3 cycles, no state change.
REQ-040 SHALL test: reset during WAIT of write 0x00FF @0x10 -> no ack, busy 0 next cycle, read @0x10 returns prior value.
REQ-041 SHALL test: DMEM_DBG_PORT_EN, 3 accesses incl. 1 out-of-range, dbg_sel=2 -> 3, dbg_sel=3 -> 1; without macro dbg_y = 0.
